// File: rtl/bayer_rgb_demosaic.sv
// rtl/bayer_rgb_demosaic.sv - 2x2 Bayer to RGB demosaic with one-line buffer (option: BAYER_RGB_DECIMATE_EN)
module bayer_rgb_demosaic #(
   parameter int LINE_WIDTH = 640,
   parameter int DATA_W     = 10,
   parameter int COORD_W    = 10
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic [DATA_W-1:0]  iDATA,
   input  logic               iDVAL,
   input  logic [COORD_W-1:0] iX_Cont,
   input  logic [COORD_W-1:0] iY_Cont,
   output logic [DATA_W-1:0]  oRed,
   output logic [DATA_W-1:0]  oGreen,
   output logic [DATA_W-1:0]  oBlue,
   output logic               oDVAL
);

   localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(LINE_WIDTH);

   logic [DATA_W-1:0]  line_buf [LINE_WIDTH];

   logic               accept;
   logic [AW-1:0]      addr;

   logic [DATA_W-1:0]  p00, p01, p10, p11;
   logic [COORD_W-1:0] x_s1, y_s1;
   logic               s1_valid;

   logic               emit;
   logic [DATA_W-1:0]  r_next, g_next, b_next;

   // Columns past the active line neither advance the window nor touch the buffer
   assign accept = iDVAL && (iX_Cont < X_LIMIT);
   assign addr   = iX_Cont[AW-1:0];

   // Previous-line storage; contents need no reset since row 0 refills it
   always_ff @(posedge iCLK) begin
      if (accept) begin
         line_buf[addr] <= iDATA;
      end
   end

   // Stage 1: shift the 2x2 window, reading the line above before it is overwritten
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         p00      <= '0;
         p01      <= '0;
         p10      <= '0;
         p11      <= '0;
         x_s1     <= '0;
         y_s1     <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            p01  <= line_buf[addr];
            p11  <= iDATA;
            p00  <= p01;
            p10  <= p11;
            x_s1 <= iX_Cont;
            y_s1 <= iY_Cont;
         end
      end
   end

   // Stage 2 colour selection: window phase decides which corners are red, blue and green
   always_comb begin
      emit   = s1_valid && (x_s1 != '0) && (y_s1 != '0);
`ifdef BAYER_RGB_DECIMATE_EN
      emit   = emit && x_s1[0] && y_s1[0];
`endif
      r_next = '0;
      g_next = '0;
      b_next = '0;
      case ({y_s1[0], x_s1[0]})
         2'b11: begin
            r_next = p01;
            b_next = p10;
            g_next = DATA_W'(({1'b0, p00} + {1'b0, p11}) >> 1);
         end
         2'b10: begin
            r_next = p00;
            b_next = p11;
            g_next = DATA_W'(({1'b0, p01} + {1'b0, p10}) >> 1);
         end
         2'b01: begin
            r_next = p11;
            b_next = p00;
            g_next = DATA_W'(({1'b0, p01} + {1'b0, p10}) >> 1);
         end
         default: begin
            r_next = p10;
            b_next = p01;
            g_next = DATA_W'(({1'b0, p00} + {1'b0, p11}) >> 1);
         end
      endcase
   end

   // Stage 2 registers: colour outputs only change on an emitted pixel
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oRed   <= '0;
         oGreen <= '0;
         oBlue  <= '0;
         oDVAL  <= 1'b0;
      end else begin
         oDVAL <= emit;
         if (emit) begin
            oRed   <= r_next;
            oGreen <= g_next;
            oBlue  <= b_next;
         end
      end
   end

endmodule

// File: tb/tb_bayer_rgb_demosaic.sv
// tb/tb_bayer_rgb_demosaic.sv - scoreboard bench for bayer_rgb_demosaic on a 4-pixel line
module tb_bayer_rgb_demosaic;

   localparam int LW = 4;
   localparam int DW = 10;
   localparam int CW = 10;

   logic          iCLK = 1'b0;
   logic          iRST;
   logic [DW-1:0] iDATA;
   logic          iDVAL;
   logic [CW-1:0] iX_Cont;
   logic [CW-1:0] iY_Cont;
   logic [DW-1:0] oRed;
   logic [DW-1:0] oGreen;
   logic [DW-1:0] oBlue;
   logic          oDVAL;

   bayer_rgb_demosaic #(
      .LINE_WIDTH (LW),
      .DATA_W     (DW),
      .COORD_W    (CW)
   ) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iDATA   (iDATA),
      .iDVAL   (iDVAL),
      .iX_Cont (iX_Cont),
      .iY_Cont (iY_Cont),
      .oRed    (oRed),
      .oGreen  (oGreen),
      .oBlue   (oBlue),
      .oDVAL   (oDVAL)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      int x;
      int y;
      int r;
      int g;
      int b;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   passed = 0;
   int   total  = 0;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int x, input int y, input int got, input int want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s at (%0d,%0d): got %0d, want %0d", name, x, y, got, want);
   endtask

   function automatic bit keep(input int x, input int y);
`ifdef BAYER_RGB_DECIMATE_EN
      return (x % 2 == 1) && (y % 2 == 1);
`else
      return 1'b1;
`endif
   endfunction

   task automatic send(input int x, input int y, input int d, input bit emit,
                       input int r, input int g, input int b);
      @(posedge iCLK);
      #1;
      iDVAL   = 1'b1;
      iX_Cont = CW'(x);
      iY_Cont = CW'(y);
      iDATA   = DW'(d);
      if (emit && keep(x, y)) sb.push_back('{x, y, r, g, b, cyc + 2});
   endtask

   task automatic sendn(input int x, input int y, input int d);
      send(x, y, d, 1'b0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge iCLK);
         #1;
         iDVAL = 1'b0;
      end
   endtask

   task automatic row0(input int d0, input int d1, input int d2, input int d3);
      sendn(0, 0, d0);
      sendn(1, 0, d1);
      sendn(2, 0, d2);
      sendn(3, 0, d3);
   endtask

   // Monitor: every strobe must match the oldest expected pixel, at the expected cycle
   always @(negedge iCLK) begin
      if (oDVAL) begin
         if (sb.size() == 0) begin
            chk("spurious_strobe", -1, -1, 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("red",     mon_e.x, mon_e.y, int'(oRed),   mon_e.r);
            chk("green",   mon_e.x, mon_e.y, int'(oGreen), mon_e.g);
            chk("blue",    mon_e.x, mon_e.y, int'(oBlue),  mon_e.b);
            chk("latency", mon_e.x, mon_e.y, cyc,          mon_e.cyc);
         end
      end
   end

   initial begin
      iRST    = 1'b0;
      iDVAL   = 1'b0;
      iDATA   = '0;
      iX_Cont = '0;
      iY_Cont = '0;
      repeat (2) @(posedge iCLK);
      #1;
      chk("reset_dval",  0, 0, int'(oDVAL),  0);
      chk("reset_red",   0, 0, int'(oRed),   0);
      chk("reset_green", 0, 0, int'(oGreen), 0);
      chk("reset_blue",  0, 0, int'(oBlue),  0);
      iRST = 1'b1;

      // Frame A: four continuous rows, plus an out-of-line column that must be ignored
      row0(100, 200, 101, 201);
      sendn(0, 1, 300);
      send(1, 1, 400, 1'b1, 200, 250, 300);
      send(2, 1, 301, 1'b1, 200, 250, 301);
      send(3, 1, 401, 1'b1, 201, 251, 301);
      sendn(4, 1, 999);
      sendn(0, 2, 500);
      send(1, 2, 600, 1'b1, 600, 450, 300);
      send(2, 2, 501, 1'b1, 600, 450, 301);
      send(3, 2, 601, 1'b1, 601, 451, 301);
      sendn(0, 3, 700);
      send(1, 3, 800, 1'b1, 600, 650, 700);
      send(2, 3, 701, 1'b1, 600, 650, 701);
      send(3, 3, 801, 1'b1, 601, 651, 701);
      idle(4);

      // Frame B: same pixels with a 3-cycle valid gap mid-row
      row0(100, 200, 101, 201);
      sendn(0, 1, 300);
      send(1, 1, 400, 1'b1, 200, 250, 300);
      idle(3);
      send(2, 1, 301, 1'b1, 200, 250, 301);
      send(3, 1, 401, 1'b1, 201, 251, 301);
      idle(4);

      // Frame C: asynchronous reset mid-row 1, then a fresh frame
      row0(100, 200, 101, 201);
      sendn(0, 1, 300);
      send(1, 1, 400, 1'b1, 200, 250, 300);
      idle(3);
`ifndef BAYER_RGB_DECIMATE_EN
      chk("hold_red",   1, 1, int'(oRed),   200);
      chk("hold_green", 1, 1, int'(oGreen), 250);
`endif
      sendn(2, 1, 301);
      @(posedge iCLK);
      #2;
      iDVAL = 1'b0;
      iRST  = 1'b0;
      #1;
      chk("midrst_dval",  2, 1, int'(oDVAL),  0);
      chk("midrst_red",   2, 1, int'(oRed),   0);
      chk("midrst_green", 2, 1, int'(oGreen), 0);
      chk("midrst_blue",  2, 1, int'(oBlue),  0);
      @(posedge iCLK);
      #1;
      iRST = 1'b1;
      row0(110, 210, 111, 211);
      sendn(0, 1, 310);
      send(1, 1, 410, 1'b1, 210, 260, 310);
      send(2, 1, 311, 1'b1, 210, 260, 311);
      send(3, 1, 411, 1'b1, 211, 261, 311);
      idle(5);

      chk("queue_empty", -1, -1, sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
